// File: rtl/wishbone_pkg.sv
// Wishbone B4 cycle/burst type codes, responder FSM states and the burst
// address sequencer shared by Wishbone blocks.
package wishbone_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        BURST,
        ERR
    } wb_state_t;

    // Next word address of an incrementing burst; wrap modes keep the upper bits.
    function automatic logic [29:0] wb_next_addr(input logic [29:0] addr, input logic [1:0] bte);
        logic [29:0] nxt;
        nxt = addr;
        case (bte)
            BTE_WRAP4:  nxt[1:0] = addr[1:0] + 2'd1;
            BTE_WRAP8:  nxt[2:0] = addr[2:0] + 3'd1;
            BTE_WRAP16: nxt[3:0] = addr[3:0] + 4'd1;
            default:    nxt      = addr + 30'd1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/apf_wishbone_ram_slave_if.sv
// Wishbone B4 pipelined-less bus bundle (32-bit data, 30-bit word address).
interface apf_wishbone_ram_slave_if;

    logic [29:0] addr;
    logic [31:0] data_write;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic [31:0] data_read;

    modport master (
        output addr, data_write, sel, we, cyc, stb, cti, bte,
        input  ack, err, data_read
    );

    modport slave (
        input  addr, data_write, sel, we, cyc, stb, cti, bte,
        output ack, err, data_read
    );

endinterface

// File: rtl/wb_bram_be.sv
// Single-port 32-bit block RAM with per-byte write enables and a registered
// read port that holds its value when no read is issued.
module wb_bram_be #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  re,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            sel,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk_sys) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)  rdata <= '0;
        else if (re)   rdata <= mem[addr];
    end

endmodule

// File: rtl/apf_wishbone_ram_slave.sv
// Wishbone B4 responder for an on-chip scratchpad: classic cycles, registered
// feedback incrementing bursts at one beat per cycle, err on out-of-window access.
module apf_wishbone_ram_slave
    import wishbone_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter logic [29:0] BASE_WORD_ADDR = 30'h0
) (
    input logic                     clk_sys,
    input logic                     reset_n,
    apf_wishbone_ram_slave_if.slave bus
);

    localparam logic [30:0] RAM_WORDS = 31'(1) << ADDR_WIDTH;

    wb_state_t             state;
    logic                  ack_q;
    logic                  err_q;
    logic [29:0]           bp;
    logic [29:0]           offset;
    logic [29:0]           bp_next;
    logic                  in_win;
    logic                  req;
    logic                  beat;
    logic                  bp_over;
    logic                  next_over;
    logic                  ram_re;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;

    // bp keeps full width so a linear burst stepping off the end is visible as bp >= RAM_WORDS.
    assign offset    = bus.addr - BASE_WORD_ADDR;
    assign in_win    = {1'b0, offset} < RAM_WORDS;
    assign req       = bus.cyc & bus.stb & ~bus.ack & ~bus.err;
    assign bp_next   = wb_next_addr(bp, bus.bte);
    assign bp_over   = {1'b0, bp} >= RAM_WORDS;
    assign next_over = {1'b0, bp_next} >= RAM_WORDS;
    assign beat      = (state == BURST) & bus.cyc & bus.stb;

    assign bus.ack = bus.cyc & (ack_q | (beat & ~bp_over));
    assign bus.err = bus.cyc & (err_q | (beat & bp_over));

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        ram_re   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = offset[ADDR_WIDTH-1:0];
        case (state)
            IDLE: begin
                if (req && in_win) begin
                    ram_re = ~bus.we;
                    ram_we = bus.we & (bus.cti != CTI_INCR);
                end
            end
            BURST: begin
                if (beat && !bp_over) begin
                    if (bus.we) begin
                        ram_we   = 1'b1;
                        ram_addr = bp[ADDR_WIDTH-1:0];
                    end else if (bus.cti != CTI_END && !next_over) begin
                        // Prefetch the next beat so data is ready with zero wait.
                        ram_re   = 1'b1;
                        ram_addr = bp_next[ADDR_WIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            bp    <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!in_win) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end else if (bus.cti == CTI_INCR) begin
                            state <= BURST;
                            bp    <= offset;
                        end else begin
                            state <= SINGLE;
                            ack_q <= 1'b1;
                        end
                    end
                end
                SINGLE, ERR: state <= IDLE;
                BURST: begin
                    if (!bus.cyc) begin
                        state <= IDLE;
                    end else if (bus.stb) begin
                        if (bp_over || bus.cti == CTI_END) state <= IDLE;
                        else                               bp    <= bp_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    wb_bram_be #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .re      (ram_re),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (bus.data_write),
        .sel     (bus.sel),
        .rdata   (bus.data_read)
    );

endmodule
